stream_mux_arb: RTL and testbench
=================================

Name: stream_mux_arb

Overview:
- Parametrised N-to-1 stream multiplexer that generalises the 2-bit 4-to-1 selector to NCH channels of W bits.
- Adds a valid/ready handshake, a one-entry registered output stage, and two selection modes: explicit index and round-robin arbitration.
- Sits between several producer units and one consumer in the npc datapath/peripheral glue, wherever several sources share one sink.

Parameters:
- NCH, 4: number of input channels; must be >= 2.
- W, 2: data width per channel in bits; must be >= 1.
- SW, $clog2(NCH): derived width of the channel index. Not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- mode  input  1  0 = explicit select via sel; 1 = round-robin arbitration
- sel  input  SW  channel index, used only when mode=0
- in_valid  input  NCH  per-channel valid; bit i belongs to channel i
- in_data  input  NCH*W  packed data; channel i occupies bits [i*W +: W]
- in_ready  output  NCH  per-channel ready; at most one bit set
- out_valid  output  1  output register holds a beat
- out_data  output  W  buffered data
- out_ch  output  SW  index of the channel that supplied out_data
- out_ready  input  1  consumer accepts the output beat

Behaviour:
- Reset, asynchronous, effective immediately:
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer ptr=0, so channel 0 has highest priority.
  - In-flight beat is discarded.
  - in_ready is all zero while rst is high.
- accept_en = !out_valid || out_ready. This is combinational, so a ready path from out_ready to in_ready exists.
- Grant vector gnt (combinational, one-hot or zero):
  - mode=0: gnt[sel]=in_valid[sel] when sel<NCH. When sel>=NCH, gnt=0 and that channel is never served.
  - mode=1: first i with in_valid[i]=1, searching ptr, ptr+1, ..., NCH-1, 0, ..., ptr-1 (wrap-around modulo NCH). gnt=0 if no valid.
- in_ready[i] = accept_en && gnt[i].
- Input transfer on channel i when in_valid[i] && in_ready[i]. At the next edge:
  - out_data <= in_data[i]
  - out_ch <= i
  - out_valid <= 1
- Output transfer when out_valid && out_ready. If there is no simultaneous input transfer, out_valid <= 0 and out_data/out_ch hold their values.
- Simultaneous output and input transfer in one cycle: the register reloads with the new beat and out_valid stays 1. This gives full throughput, one beat per cycle.
- Latency: an input accepted in cycle t appears on out_* in cycle t+1.
- Output stability: while out_valid=1 && out_ready=0, out_data and out_ch are held constant and in_ready=0.
- ptr update:
  - Only on an input transfer with mode=1: ptr <= (granted index + 1) mod NCH. NCH-1 wraps to 0.
  - mode=0 transfers leave ptr unchanged.
- Mode or sel changes take effect on the next grant evaluation (same cycle, combinational). A beat already buffered is unaffected.
- Producers must hold in_valid and in_data until they see in_ready. The block does not drop a beat once it is accepted.
- A non-power-of-2 NCH is supported. Indices >= NCH never appear on out_ch.

Test Plan:
- Reset: assert rst mid-transfer with out_valid=1 → out_valid, out_data, out_ch go to 0 immediately with no clock; in_ready=0. After release, first mode=1 grant goes to the lowest valid index from 0.
- Explicit mode: mode=0, sel=2, in_valid=4'b1111, in_data ch0..3 = 0,1,2,3, out_ready=1 → in_ready=4'b0100; next cycle out_data=2'b10, out_ch=2. Then sel=3 → out_data=3 one cycle later.
- Round-robin fairness: mode=1, all valid, out_ready=1 for 8 cycles → out_ch sequence 0,1,2,3,0,1,2,3 at one beat per cycle. With in_valid=4'b1010 from reset → 1,3,1,3.
- Backpressure: out_ready=0 after the first beat (ch1, data 1) → out_valid=1 and out_data=1 held, in_ready=0 for 5 cycles. Raising out_ready → the same-cycle reload delivers the next grant (ch2 if valid) on the following cycle with no bubble.
- Boundaries:
  - NCH=3, W=8: mode=0 with sel=3 → no grant and out_valid stays 0.
  - ptr at 2 with only ch0 valid → grant wraps to 0 and ptr becomes 1.
- Mode switch: switch mode 1→0 while a beat is buffered and out_ready=0 → buffered out_data/out_ch unchanged. The next grant follows sel; ptr is unchanged by the mode=0 transfer.

Source files
------------

// File: rtl/stream_mux_arb.sv
// rtl/stream_mux_arb.sv - N-to-1 valid/ready stream mux with explicit-select and round-robin modes
module stream_mux_arb #(
    parameter int NCH = 4,
    parameter int W   = 2,
    parameter int SW  = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [SW-1:0]    sel,
    input  logic [NCH-1:0]   in_valid,
    input  logic [NCH*W-1:0] in_data,
    output logic [NCH-1:0]   in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [SW-1:0]    out_ch,
    input  logic             out_ready
);

    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic [SW-1:0]   out_ch_q, out_ch_d;
    logic [SW-1:0]   ptr_q, ptr_d;

    logic            accept_en;
    logic            in_xfer;
    logic            gnt_any;
    logic [SW-1:0]   gnt_idx;
    logic [NCH-1:0]  gnt;
    logic [W-1:0]    gnt_data;
    logic            hi_found, lo_found;
    logic [SW-1:0]   hi_idx, lo_idx;

    // Round-robin: the lowest valid index at or above ptr wins; otherwise the
    // lowest valid index overall, which then necessarily lies below ptr.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = SW'(i);
                if (SW'(i) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = SW'(i);
                end
            end
        end
    end

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (mode) begin
            gnt_any = hi_found | lo_found;
            gnt_idx = hi_found ? hi_idx : lo_idx;
        end else begin
            gnt_idx = sel;
            for (int i = 0; i < NCH; i++) begin
                if (sel == SW'(i)) begin
                    gnt_any = in_valid[i];
                end
            end
        end
    end

    always_comb begin
        gnt      = '0;
        gnt_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt_idx == SW'(i)) begin
                gnt[i]   = gnt_any;
                gnt_data = in_data[i*W +: W];
            end
        end
    end

    assign accept_en = !out_valid_q || out_ready;
    assign in_xfer   = accept_en && gnt_any;
    assign in_ready  = {NCH{accept_en && !rst}} & gnt;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (in_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data;
            out_ch_d    = gnt_idx;
            if (mode) begin
                ptr_d = (gnt_idx == SW'(NCH - 1)) ? '0 : gnt_idx + SW'(1);
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// tb/tb_stream_mux_arb.sv - scoreboard bench for stream_mux_arb (NCH=4/W=2 and NCH=3/W=8)
module tb_stream_mux_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic [1:0] sel;
    logic [3:0] in_valid;
    logic [7:0] in_data;
    logic [3:0] in_ready;
    logic       out_valid;
    logic [1:0] out_data;
    logic [1:0] out_ch;
    logic       out_ready;

    logic        mode3;
    logic [1:0]  sel3;
    logic [2:0]  in_valid3;
    logic [23:0] in_data3;
    logic [2:0]  in_ready3;
    logic        out_valid3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_ready3;

    int errors = 0;
    int checks = 0;

    bit         m_ov;
    int         m_ptr;
    logic [3:0] sbq[$];

    always #5 clk = ~clk;

    stream_mux_arb #(.NCH(4), .W(2)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    stream_mux_arb #(.NCH(3), .W(8)) dut3 (
        .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3),
        .out_ready(out_ready3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int mgrant(input bit md, input int s, input logic [3:0] v, input int p);
        if (!md) return v[s] ? s : -1;
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // One clock: check combinational ready and buffered output, then advance the model.
    task automatic step(input string tag);
        int         g;
        bit         acc, ixf, oxf;
        logic [3:0] exp_rdy;
        logic [3:0] head;
        #1;
        g       = mgrant(mode, int'(sel), in_valid, m_ptr);
        acc     = !m_ov || out_ready;
        exp_rdy = (acc && g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
        if (m_ov && sbq.size() > 0) begin
            head = sbq[0];
            chk({tag, ".out_data"}, 32'(out_data), 32'(head[1:0]));
            chk({tag, ".out_ch"}, 32'(out_ch), 32'(head[3:2]));
        end
        ixf = acc && g >= 0;
        oxf = m_ov && out_ready;
        @(posedge clk);
        if (oxf && sbq.size() > 0) void'(sbq.pop_front());
        if (ixf) begin
            sbq.push_back({g[1:0], in_data[g*2 +: 2]});
            if (mode) m_ptr = (g + 1) % 4;
        end
        m_ov = ixf ? 1'b1 : (oxf ? 1'b0 : m_ov);
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        step("drain");
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'b1111;
        in_data = {2'd3, 2'd2, 2'd1, 2'd0}; out_ready = 1'b1;
        mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b000; in_data3 = 24'h332211; out_ready3 = 1'b1;
        m_ov = 1'b0; m_ptr = 0;
        #2;
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // explicit select
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111;
        #1 chk("explicit.in_ready_0100", 32'(in_ready), 32'h4);
        step("explicit_sel2");
        sel = 2'd3;
        step("explicit_sel3");
        drain();

        // round-robin, all valid, eight beats back to back
        mode = 1'b1; in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) step("rr_all");
        drain();

        // asynchronous reset while a beat is buffered
        in_valid = 4'b0010;
        step("pre_reset");
        #2 rst = 1'b1;
        #1;
        chk("async_reset.out_valid", 32'(out_valid), 32'd0);
        chk("async_reset.out_data", 32'(out_data), 32'd0);
        chk("async_reset.out_ch", 32'(out_ch), 32'd0);
        chk("async_reset.in_ready", 32'(in_ready), 32'd0);
        sbq.delete(); m_ov = 1'b0; m_ptr = 0;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) step("rr_1010");
        drain();

        // backpressure then same-cycle reload
        in_valid = 4'b0010;
        step("bp_first");
        in_valid = 4'b1111; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) step("bp_hold");
        out_ready = 1'b1;
        step("bp_release");
        drain();

        // pointer wrap: ptr=2 with only ch0 valid
        in_valid = 4'b0010;
        step("wrap_set_ptr2");
        in_valid = 4'b0001;
        step("wrap_ch0");
        in_valid = 4'b1111;
        step("wrap_ptr1");
        drain();

        // mode switch with a buffered beat
        in_valid = 4'b1111;
        step("msw_load");
        out_ready = 1'b0; mode = 1'b0; sel = 2'd0;
        step("msw_hold");
        step("msw_hold");
        out_ready = 1'b1;
        step("msw_sel0");
        mode = 1'b1;
        step("msw_ptr_kept");
        drain();
        drain();

        // NCH=3: out-of-range select never grants
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
        #1 chk("nch3.sel3_in_ready", 32'(in_ready3), 32'd0);
        @(negedge clk);
        chk("nch3.sel3_out_valid", 32'(out_valid3), 32'd0);
        sel3 = 2'd2;
        #1 chk("nch3.sel2_in_ready", 32'(in_ready3), 32'h4);
        @(negedge clk);
        chk("nch3.sel2_out_valid", 32'(out_valid3), 32'd1);
        chk("nch3.sel2_out_data", 32'(out_data3), 32'h33);
        chk("nch3.sel2_out_ch", 32'(out_ch3), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
